inst_sram_responder: RTL and testbench

Responder end of the instruction SRAM interface driven by the fetch stage. It accepts one request per cycle (`en`, `wen`, `addr`, `wdata`) and returns `rdata` one cycle later from a word-organised on-chip array. Addresses are translated from kseg0/kseg1 to physical. Byte-lane writes let the bench and the boot loader fill the array. It sits between the CPU's fetch port and the instruction memory in the SoC wrapper and also serves as the simulation instruction memory.

---
 rtl/inst_sram_responder.sv | 90 +++++++++
 tb/tb_inst_sram_responder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: word array with kseg0/kseg1 translation, byte-lane
// writes, read-first 1-cycle responses, out-of-range flagging and a read counter.
module inst_sram_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1fc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        oor_err,
    output logic [31:0] fetch_cnt
);

    // Handshake: inst_sram_en is the request valid; the responder is always
    // ready, so every cycle with en=1 (and reset=0) is an accepted request and
    // its response appears on inst_sram_rdata/oor_err exactly one cycle later.

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       paddr;
    logic [29:0]       word_off;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
    logic              is_read;
    logic              do_write;

    logic [31:0] rdata_q, rdata_d;
    logic        oor_q, oor_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        paddr = inst_sram_addr;
        if (inst_sram_addr[31:30] == 2'b10) begin
            paddr = {3'b000, inst_sram_addr[28:0]};
        end
    end

    // Unsigned 30-bit word offset from the base; wraps for addresses below it.
    assign word_off = paddr[31:2] - BASE_ADDR[31:2];
    assign in_range = (word_off >> ADDR_W) == 30'd0;
    assign idx      = word_off[ADDR_W-1:0];
    assign is_read  = inst_sram_en && (inst_sram_wen == 4'h0);
    assign do_write = !reset && inst_sram_en && (inst_sram_wen != 4'h0) && in_range;

    always_comb begin
        rdata_d = rdata_q;
        oor_d   = 1'b0;
        cnt_d   = cnt_q;
        if (inst_sram_en) begin
            rdata_d = in_range ? mem[idx] : 32'h0;
            oor_d   = !in_range;
        end
        if (is_read && (cnt_q != 32'hffffffff)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 32'h0;
            oor_q   <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
        end
    end

    // The array has no reset; contents survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (inst_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign inst_sram_rdata = rdata_q;
    assign oor_err         = oor_q;
    assign fetch_cnt       = cnt_q;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed self-checking bench for inst_sram_responder with hand-computed
// expectations checked by immediate assertions.
module tb_inst_sram_responder;

    logic        clk;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        oor_err;
    logic [31:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    inst_sram_responder dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .oor_err         (oor_err),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        inst_sram_en    = en;
        inst_sram_wen   = wen;
        inst_sram_addr  = addr;
        inst_sram_wdata = wdata;
    endtask

    // Advance one clock and settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset_rdata", inst_sram_rdata, 32'h0);
        check("reset_oor", {31'h0, oor_err}, 32'h0);
        check("reset_cnt", fetch_cnt, 32'h0);

        // Boot fetch
        reset = 1'b0;
        drive(1'b1, 4'hf, 32'hbfc00000, 32'h3c1d0000);
        tick();
        check("boot_wr_oor", {31'h0, oor_err}, 32'h0);
        check("boot_wr_cnt", fetch_cnt, 32'h0);
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("boot_rdata", inst_sram_rdata, 32'h3c1d0000);
        check("boot_cnt", fetch_cnt, 32'd1);

        // Byte lanes, read-first on the partial write
        drive(1'b1, 4'hf, 32'hbfc00004, 32'h11223344);
        tick();
        drive(1'b1, 4'b0101, 32'hbfc00004, 32'haabbccdd);
        tick();
        check("lane_readfirst", inst_sram_rdata, 32'h11223344);
        drive(1'b1, 4'h0, 32'hbfc00004, 32'h0);
        tick();
        check("lane_merge", inst_sram_rdata, 32'h11bb33dd);
        check("lane_cnt", fetch_cnt, 32'd2);

        // Hold with toggling idle inputs (wen set to catch ungated writes)
        drive(1'b1, 4'hf, 32'hbfc00008, 32'hdeadbeef);
        tick();
        drive(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        tick();
        check("hold_first", inst_sram_rdata, 32'hdeadbeef);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hf, (i % 2 == 0) ? 32'h00000000 : 32'hbfc00008,
                  (i % 2 == 0) ? 32'h55555555 : 32'haaaaaaaa);
            tick();
            check("hold_rdata", inst_sram_rdata, 32'hdeadbeef);
            check("hold_oor", {31'h0, oor_err}, 32'h0);
            check("hold_cnt", fetch_cnt, 32'd3);
        end
        drive(1'b1, 4'h0, 32'hbfc00008, 32'h0);
        tick();
        check("hold_nowrite", inst_sram_rdata, 32'hdeadbeef);

        // Out of range read and write at physical 0
        drive(1'b1, 4'h0, 32'h00000000, 32'h0);
        tick();
        check("oor_rd_rdata", inst_sram_rdata, 32'h0);
        check("oor_rd_flag", {31'h0, oor_err}, 32'h1);
        check("oor_rd_cnt", fetch_cnt, 32'd5);
        drive(1'b1, 4'hf, 32'h00000000, 32'h12345678);
        tick();
        check("oor_wr_rdata", inst_sram_rdata, 32'h0);
        check("oor_wr_flag", {31'h0, oor_err}, 32'h1);
        check("oor_wr_cnt", fetch_cnt, 32'd5);
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        check("oor_pulse_end", {31'h0, oor_err}, 32'h0);
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("oor_idx0_intact", inst_sram_rdata, 32'h3c1d0000);
        check("oor_idx0_flag", {31'h0, oor_err}, 32'h0);

        // Array edges: last word in range, one past it and one below base out
        drive(1'b1, 4'hf, 32'hbfc03ffc, 32'h0a0b0c0d);
        tick();
        drive(1'b1, 4'h0, 32'hbfc03ffc, 32'h0);
        tick();
        check("top_word", inst_sram_rdata, 32'h0a0b0c0d);
        check("top_flag", {31'h0, oor_err}, 32'h0);
        drive(1'b1, 4'h0, 32'hbfc04000, 32'h0);
        tick();
        check("past_top_rdata", inst_sram_rdata, 32'h0);
        check("past_top_flag", {31'h0, oor_err}, 32'h1);
        drive(1'b1, 4'h0, 32'hbfbffffc, 32'h0);
        tick();
        check("below_base_flag", {31'h0, oor_err}, 32'h1);
        check("edge_cnt", fetch_cnt, 32'd9);

        // Aliasing: write via kseg0, read via kseg1 and physical back-to-back
        drive(1'b1, 4'hf, 32'h9fc00010, 32'hcafe0001);
        tick();
        drive(1'b1, 4'h0, 32'hbfc00010, 32'h0);
        tick();
        drive(1'b1, 4'h0, 32'h1fc00010, 32'h0);
        check("alias_kseg1", inst_sram_rdata, 32'hcafe0001);
        tick();
        check("alias_phys", inst_sram_rdata, 32'hcafe0001);
        check("alias_cnt", fetch_cnt, 32'd11);

        // Reset mid-stream with a write request present
        reset = 1'b1;
        drive(1'b1, 4'hf, 32'hbfc00000, 32'hffffffff);
        tick();
        check("rst_mid_rdata", inst_sram_rdata, 32'h0);
        check("rst_mid_cnt", fetch_cnt, 32'h0);
        check("rst_mid_oor", {31'h0, oor_err}, 32'h0);
        reset = 1'b0;
        drive(1'b1, 4'h0, 32'hbfc00000, 32'h0);
        tick();
        check("rst_mem_kept", inst_sram_rdata, 32'h3c1d0000);
        check("rst_cnt_restart", fetch_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
